// File: rtl/ramb16_port_pkg.sv
// Shared definitions for the RAMB16_S2 port master: FSM encoding and default geometry.
package ramb16_port_pkg;

    localparam int unsigned AW_DEF = 13;
    localparam int unsigned DW_DEF = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/ram_rsp_fifo.sv
// Small synchronous response FIFO with occupancy count; head is visible while not empty.
module ram_rsp_fifo #(
    parameter int DW    = 2,
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          ssr,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign empty     = (count_r == {CW{1'b0}});
    assign full_s    = (count_r == CW'(DEPTH));
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full_s || pop_ok_s);
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array: data only, no reset so it maps onto plain registers/LUT RAM.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (ssr) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ramb16_s2_port_master.sv
// Host-side initiator for one RAMB16_S2 port: request channel, buffered read
// responses that hide the one-cycle RAM latency, and a whole-array fill engine.
module ramb16_s2_port_master
    import ramb16_port_pkg::*;
#(
    parameter int ADDR_WIDTH = AW_DEF,
    parameter int DATA_WIDTH = DW_DEF,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  ssr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic                  ram_ssr,
    input  logic [DATA_WIDTH-1:0] ram_do
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   fill_cnt_r;
    logic [DATA_WIDTH-1:0]   fill_val_r;
    logic                    fill_done_r;
    logic                    rd_inflight_r;
    logic                    fill_last_s;
    logic                    accept_s;
    logic                    accept_rd_s;
    logic                    credit_ok_s;
    logic                    rsp_valid_s;
    logic                    pop_s;
    logic                    fifo_empty_s;
    logic [CW-1:0]           fifo_count_s;
    logic [CW:0]             used_s;
    logic [CW:0]             limit_s;

    assign fill_last_s = (fill_cnt_r == {ADDR_WIDTH{1'b1}});

    // Read credit: slots already owed (buffered + in flight) must leave room for one more.
    // A slot vacated by a same-cycle pop counts as free, which keeps reads streaming at
    // one per cycle while the host drains responses.
    assign used_s      = {1'b0, fifo_count_s} + {{CW{1'b0}}, rd_inflight_r};
    assign limit_s     = (CW + 1)'(RSP_DEPTH) + {{CW{1'b0}}, pop_s};
    assign credit_ok_s = (used_s < limit_s);

    assign rsp_valid_s = !fifo_empty_s && !ssr;
    assign pop_s       = rsp_valid_s && rsp_ready;
    assign accept_rd_s = accept_s && !req_we;

    assign rsp_valid = rsp_valid_s;
    assign fill_busy = (state_r == FILL) && !ssr;
    assign fill_done = fill_done_r && !ssr;
    assign ram_ssr   = 1'b0;

    // Next-state and RAM port drive; RAM pins are combinational so the RAM samples them on the accepting edge.
    always_comb begin
        state_nxt_s = state_r;
        req_ready   = 1'b0;
        accept_s    = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = {ADDR_WIDTH{1'b0}};
        ram_di      = {DATA_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (ssr) begin
                    state_nxt_s = IDLE;
                end else begin
                    // A fill request takes priority; writes need no response slot.
                    req_ready = !fill_start && (req_we || credit_ok_s);
                    accept_s  = req_valid && req_ready;
                    if (fill_start) begin
                        state_nxt_s = FILL;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                    if (accept_s) begin
                        ram_en   = 1'b1;
                        ram_we   = req_we;
                        ram_addr = req_addr;
                        ram_di   = req_data;
                    end else begin
                        ram_en   = 1'b0;
                    end
                end
            end
            FILL: begin
                if (ssr) begin
                    state_nxt_s = IDLE;
                end else begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = fill_cnt_r;
                    ram_di   = fill_val_r;
                    if (fill_last_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (ssr) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fill engine: counter, latched fill value and the completion pulse.
    always_ff @(posedge clk) begin
        if (ssr) begin
            fill_cnt_r  <= {ADDR_WIDTH{1'b0}};
            fill_val_r  <= {DATA_WIDTH{1'b0}};
            fill_done_r <= 1'b0;
        end else begin
            fill_done_r <= (state_r == FILL) && fill_last_s;
            if ((state_r == IDLE) && fill_start) begin
                fill_cnt_r <= {ADDR_WIDTH{1'b0}};
                fill_val_r <= fill_value;
            end else if ((state_r == FILL) && !fill_last_s) begin
                fill_cnt_r <= fill_cnt_r + ADDR_WIDTH'(1);
            end
        end
    end

    // Marks that RAM_DO carries read data in the following cycle.
    always_ff @(posedge clk) begin
        if (ssr) begin
            rd_inflight_r <= 1'b0;
        end else begin
            rd_inflight_r <= accept_rd_s;
        end
    end

    ram_rsp_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .ssr       (ssr),
        .push      (rd_inflight_r),
        .push_data (ram_do),
        .pop       (pop_s),
        .head      (rsp_data),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s)
    );

endmodule
